// File: rtl/lz4_wb_stream_bridge.sv
// Wishbone-to-byte-stream bridge for the LZ4 decoder subsystem.
// Each channel has an input FIFO (Wishbone DATA writes -> decoder) and an
// output FIFO (decoder -> Wishbone DATA reads). Status, flush, sticky error
// flags and interrupt enables are available per channel. The bus side is a
// two-state IDLE/ACK machine, so every access completes in two cycles.
module lz4_wb_stream_bridge #(
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_en,
    input  logic [7:0]            addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic [8*CHANNELS-1:0] cmp_data,
    output logic [CHANNELS-1:0]   cmp_valid,
    input  logic [CHANNELS-1:0]   cmp_ready,
    input  logic [8*CHANNELS-1:0] dcmp_data,
    input  logic [CHANNELS-1:0]   dcmp_valid,
    output logic [CHANNELS-1:0]   dcmp_ready,
    output logic                  irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        access;
    logic [3:0]  ch_idx;
    logic [1:0]  reg_idx;
    logic [31:0] read_value;

    // Per-channel views gathered for the read mux and the interrupt OR.
    logic [CHANNELS-1:0] irq_src;
    logic [CHANNELS-1:0] out_empty;
    logic [31:0]         status_word [CHANNELS];
    logic [31:0]         ctrl_word   [CHANNELS];
    logic [7:0]          out_head    [CHANNELS];

    // Address bits that carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    assign ch_idx  = addr[7:4];
    assign reg_idx = addr[3:2];

    // Bus state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bus next-state: an access is taken only in IDLE, ACK always returns to IDLE.
    always_comb begin
        state_next = state_reg;
        access     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid) begin
                    access     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [7:0]    in_mem  [FIFO_DEPTH];
            logic [7:0]    out_mem [FIFO_DEPTH];
            logic [AW-1:0] in_wr_ptr_reg;
            logic [AW-1:0] in_rd_ptr_reg;
            logic [AW-1:0] out_wr_ptr_reg;
            logic [AW-1:0] out_rd_ptr_reg;
            logic [LW-1:0] in_level_reg;
            logic [LW-1:0] out_level_reg;
            logic          overflow_reg;
            logic          underflow_reg;
            logic          ie_in_reg;
            logic          ie_out_reg;

            logic sel;
            logic data_wr;
            logic data_rd;
            logic ctrl_wr;
            logic flush;
            logic clr_sticky;
            logic in_full_c;
            logic in_empty_c;
            logic out_full_c;
            logic out_empty_c;
            logic in_push;
            logic in_pop;
            logic out_push;
            logic out_pop;

            assign sel     = access && (int'(ch_idx) == gi);
            assign data_wr = sel && wr_en && (reg_idx == 2'd0);
            assign data_rd = sel && !wr_en && (reg_idx == 2'd0);
            assign ctrl_wr = sel && wr_en && (reg_idx == 2'd2);

            assign flush      = ctrl_wr && wdata[2];
            assign clr_sticky = ctrl_wr && wdata[3];

            // Full/empty come from the level registered at the start of the cycle.
            assign in_full_c   = (in_level_reg == LW'(FIFO_DEPTH));
            assign in_empty_c  = (in_level_reg == '0);
            assign out_full_c  = (out_level_reg == LW'(FIFO_DEPTH));
            assign out_empty_c = (out_level_reg == '0);

            // A Wishbone push into a full FIFO is dropped even if the stream pops now;
            // flush discards any stream traffic in the same cycle.
            assign in_push  = data_wr && !in_full_c;
            assign in_pop   = !in_empty_c && cmp_ready[gi] && !flush;
            assign out_push = dcmp_valid[gi] && !out_full_c && !flush;
            assign out_pop  = data_rd && !out_empty_c;

            assign cmp_data[8*gi +: 8] = in_mem[in_rd_ptr_reg];
            assign cmp_valid[gi]       = !in_empty_c;
            assign dcmp_ready[gi]      = !out_full_c;
            assign out_head[gi]        = out_mem[out_rd_ptr_reg];
            assign out_empty[gi]       = out_empty_c;

            assign status_word[gi] = {8'd0, 8'(out_level_reg), 8'(in_level_reg),
                                      2'b00, underflow_reg, overflow_reg,
                                      out_empty_c, out_full_c, in_empty_c, in_full_c};
            assign ctrl_word[gi]   = {30'd0, ie_in_reg, ie_out_reg};
            assign irq_src[gi]     = (ie_out_reg && !out_empty_c) || (ie_in_reg && in_empty_c);

            // FIFO storage writes; no reset so the arrays map onto RAM.
            always_ff @(posedge clk) begin
                if (in_push) begin
                    in_mem[in_wr_ptr_reg] <= wdata[7:0];
                end
                if (out_push) begin
                    out_mem[out_wr_ptr_reg] <= dcmp_data[8*gi +: 8];
                end
            end

            // Pointer and level bookkeeping for both FIFOs, with flush override.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    in_wr_ptr_reg  <= '0;
                    in_rd_ptr_reg  <= '0;
                    out_wr_ptr_reg <= '0;
                    out_rd_ptr_reg <= '0;
                    in_level_reg   <= '0;
                    out_level_reg  <= '0;
                end else if (flush) begin
                    in_wr_ptr_reg  <= '0;
                    in_rd_ptr_reg  <= '0;
                    out_wr_ptr_reg <= '0;
                    out_rd_ptr_reg <= '0;
                    in_level_reg   <= '0;
                    out_level_reg  <= '0;
                end else begin
                    if (in_push) in_wr_ptr_reg <= in_wr_ptr_reg + AW'(1);
                    if (in_pop) in_rd_ptr_reg <= in_rd_ptr_reg + AW'(1);
                    if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + AW'(1);
                    if (out_pop) out_rd_ptr_reg <= out_rd_ptr_reg + AW'(1);
                    in_level_reg  <= in_level_reg + LW'(in_push) - LW'(in_pop);
                    out_level_reg <= out_level_reg + LW'(out_push) - LW'(out_pop);
                end
            end

            // Sticky error flags and interrupt enables.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    overflow_reg  <= 1'b0;
                    underflow_reg <= 1'b0;
                    ie_in_reg     <= 1'b0;
                    ie_out_reg    <= 1'b0;
                end else begin
                    if (clr_sticky) begin
                        overflow_reg  <= 1'b0;
                        underflow_reg <= 1'b0;
                    end else begin
                        if (data_wr && in_full_c) overflow_reg <= 1'b1;
                        if (data_rd && out_empty_c) underflow_reg <= 1'b1;
                    end
                    if (ctrl_wr) begin
                        ie_out_reg <= wdata[0];
                        ie_in_reg  <= wdata[1];
                    end
                end
            end
        end
    endgenerate

    // Read data mux; out-of-range channels, reserved registers and writes give 0.
    always_comb begin
        read_value = 32'd0;
        if (!wr_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (int'(ch_idx) == c) begin
                    case (reg_idx)
                        2'd0: read_value = out_empty[c] ? 32'd0 : {23'd0, 1'b1, out_head[c]};
                        2'd1: read_value = status_word[c];
                        2'd2: read_value = ctrl_word[c];
                        default: read_value = 32'd0;
                    endcase
                end
            end
        end
    end

    // Registered acknowledge, read data and interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready <= 1'b0;
            rdata <= 32'd0;
            irq   <= 1'b0;
        end else begin
            ready <= access;
            if (access) begin
                rdata <= read_value;
            end
            irq <= |irq_src;
        end
    end

endmodule

// File: tb/tb_lz4_wb_stream_bridge.sv
// Directed bench for lz4_wb_stream_bridge (CHANNELS=2, FIFO_DEPTH=16).
module tb_lz4_wb_stream_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic [15:0] cmp_data;
    logic [1:0]  cmp_valid;
    logic [1:0]  cmp_ready = 2'b00;
    logic [15:0] dcmp_data = 16'd0;
    logic [1:0]  dcmp_valid = 2'b00;
    logic [1:0]  dcmp_ready;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    logic       stress_done = 1'b0;

    lz4_wb_stream_bridge #(.CHANNELS(2), .FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .wr_en      (wr_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .cmp_data   (cmp_data),
        .cmp_valid  (cmp_valid),
        .cmp_ready  (cmp_ready),
        .dcmp_data  (dcmp_data),
        .dcmp_valid (dcmp_valid),
        .dcmp_ready (dcmp_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // One bus transaction: drive at a falling edge, sampled at the next rising
    // edge, ack/rdata captured at the following falling edge.
    task automatic bus(input logic we, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic ack);
        @(negedge clk);
        valid = 1'b1;
        wr_en = we;
        addr  = a;
        wdata = d;
        @(negedge clk);
        ack   = ready;
        rd    = rdata;
        valid = 1'b0;
        wr_en = 1'b0;
        $display("WB %s addr=%02h wdata=%08h rdata=%08h ack=%0b", we ? "WR" : "RD", a, d, rd, ack);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic ack;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", ready); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %08h want 0", rdata); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cmp_valid !== 2'b00) begin errors++; $display("FAIL reset_cmp_valid got %b want 00", cmp_valid); end
        checks++; if (dcmp_ready !== 2'b11) begin errors++; $display("FAIL reset_dcmp_ready got %b want 11", dcmp_ready); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", irq); end
        bus(1'b0, 8'h04, 32'd0, rd, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL reset_status_ack got %0b want 1", ack); end
        checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL reset_status got %08h want 0000000a", rd); end
        // ready is a single-cycle pulse
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got %0b want 0", ready); end
    endtask

    task automatic test_stream_order();
        logic [31:0] rd;
        logic ack;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        cmp_ready[1] = 1'b0;
        for (int i = 0; i < 3; i++) bus(1'b1, 8'h10, {24'd0, exp_b[i]}, rd, ack);
        bus(1'b0, 8'h14, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_0308) begin errors++; $display("FAIL ch1_status_lvl3 got %08h want 00000308", rd); end
        @(negedge clk);
        cmp_ready[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmp_valid[1] !== 1'b1 || cmp_data[15:8] !== exp_b[i]) begin
                errors++; $display("FAIL ch1_stream[%0d] got v=%0b d=%02h want v=1 d=%02h", i, cmp_valid[1], cmp_data[15:8], exp_b[i]);
            end
            @(negedge clk);
        end
        checks++; if (cmp_valid[1] !== 1'b0) begin errors++; $display("FAIL ch1_drained got %0b want 0", cmp_valid[1]); end
        cmp_ready[1] = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic ack;
        cmp_ready[0] = 1'b0;
        for (int i = 0; i < 17; i++) bus(1'b1, 8'h00, 32'h40 + i, rd, ack);
        bus(1'b0, 8'h04, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_1019) begin errors++; $display("FAIL ovf_status got %08h want 00001019", rd); end
        checks++; if (cmp_data[7:0] !== 8'h40) begin errors++; $display("FAIL ovf_head got %02h want 40", cmp_data[7:0]); end
        bus(1'b1, 8'h08, 32'h8, rd, ack);
        bus(1'b0, 8'h04, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_1009) begin errors++; $display("FAIL ovf_cleared got %08h want 00001009", rd); end
    endtask

    task automatic test_irq_data_read();
        logic [31:0] rd;
        logic ack;
        bus(1'b1, 8'h08, 32'h1, rd, ack);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %0b want 0", irq); end
        dcmp_valid[0] = 1'b1;
        dcmp_data[7:0] = 8'hA5;
        @(negedge clk);
        dcmp_valid[0] = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag got %0b want 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_raise got %0b want 1", irq); end
        bus(1'b0, 8'h00, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_01A5) begin errors++; $display("FAIL data_read got %08h want 000001a5", rd); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got %0b want 0", irq); end
        bus(1'b0, 8'h00, 32'd0, rd, ack);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL empty_read got %08h want 0", rd); end
        bus(1'b0, 8'h04, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_1029) begin errors++; $display("FAIL udf_status got %08h want 00001029", rd); end
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        logic ack;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            dcmp_valid[0] = 1'b1;
            dcmp_data[7:0] = 8'h50 + 8'(k);
        end
        @(negedge clk);
        dcmp_valid[0] = 1'b0;
        checks++; if (dcmp_ready[0] !== 1'b0) begin errors++; $display("FAIL out_full_ready got %0b want 0", dcmp_ready[0]); end
        bus(1'b0, 8'h04, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0010_1025) begin errors++; $display("FAIL both_full_status got %08h want 00101025", rd); end
        bus(1'b1, 8'h10, 32'h77, rd, ack);
        bus(1'b1, 8'h08, 32'h5, rd, ack);
        bus(1'b0, 8'h04, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_002A) begin errors++; $display("FAIL flush_status got %08h want 0000002a", rd); end
        bus(1'b0, 8'h08, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL flush_ctrl got %08h want 00000001", rd); end
        checks++; if (cmp_valid[0] !== 1'b0 || dcmp_ready[0] !== 1'b1) begin
            errors++; $display("FAIL flush_stream got v=%0b r=%0b want v=0 r=1", cmp_valid[0], dcmp_ready[0]);
        end
        bus(1'b0, 8'h14, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_0108) begin errors++; $display("FAIL ch1_untouched got %08h want 00000108", rd); end
        checks++; if (cmp_data[15:8] !== 8'h77) begin errors++; $display("FAIL ch1_head got %02h want 77", cmp_data[15:8]); end
        bus(1'b1, 8'h08, 32'hC, rd, ack);
        bus(1'b0, 8'h04, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL flush_clear got %08h want 0000000a", rd); end
    endtask

    task automatic test_reserved();
        logic [31:0] rd;
        logic ack;
        bus(1'b0, 8'h0C, 32'd0, rd, ack);
        checks++; if (rd !== 32'd0 || ack !== 1'b1) begin errors++; $display("FAIL reg3_read got %08h ack=%0b want 0 ack=1", rd, ack); end
        bus(1'b0, 8'h24, 32'd0, rd, ack);
        checks++; if (rd !== 32'd0 || ack !== 1'b1) begin errors++; $display("FAIL ch2_read got %08h ack=%0b want 0 ack=1", rd, ack); end
        bus(1'b1, 8'h30, 32'h99, rd, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ch3_write_ack got %0b want 1", ack); end
        bus(1'b0, 8'h14, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_0108) begin errors++; $display("FAIL ch3_write_ignored got %08h want 00000108", rd); end
    endtask

    task automatic test_back_to_back_stress();
        logic [31:0] rd;
        logic ack;
        int wr_cnt;
        int rd_cnt;
        wr_cnt = 0;
        rd_cnt = 0;
        stress_done = 1'b0;
        fork
            // Bus: alternate DATA writes and DATA reads on channel 0.
            begin
                for (int t = 0; t < 800 && (wr_cnt < 48 || rd_cnt < 48); t++) begin
                    if ((t % 2 == 0) && wr_cnt < 48) begin
                        in_q.push_back(8'(wr_cnt + 1));
                        bus(1'b1, 8'h00, 32'(wr_cnt + 1), rd, ack);
                        wr_cnt++;
                    end else begin
                        bus(1'b0, 8'h00, 32'd0, rd, ack);
                        if (rd[8] === 1'b1) begin
                            checks++;
                            if (out_q.size() == 0 || rd !== {23'd0, 1'b1, out_q[0]}) begin
                                errors++; $display("FAIL stress_out[%0d] got %08h want %02h", rd_cnt, rd, (out_q.size() == 0) ? 8'h00 : out_q[0]);
                            end
                            if (out_q.size() != 0) void'(out_q.pop_front());
                            rd_cnt++;
                        end
                    end
                end
                stress_done = 1'b1;
            end
            // Decoder: offers 48 bytes with random gaps.
            begin
                int k;
                k = 0;
                for (int n = 0; n < 2000 && k < 48; n++) begin
                    @(negedge clk);
                    dcmp_valid[0] = 1'($urandom_range(0, 1));
                    dcmp_data[7:0] = 8'h80 + 8'(k);
                    if (dcmp_valid[0] && dcmp_ready[0]) begin
                        out_q.push_back(8'h80 + 8'(k));
                        k++;
                    end
                end
                @(negedge clk);
                dcmp_valid[0] = 1'b0;
            end
            // Compressed-stream sink with random back-pressure.
            begin
                for (int n = 0; n < 3000; n++) begin
                    @(negedge clk);
                    if (stress_done && in_q.size() == 0) break;
                    cmp_ready[0] = ($urandom_range(0, 3) != 0);
                    if (cmp_valid[0] && cmp_ready[0]) begin
                        checks++;
                        if (in_q.size() == 0 || cmp_data[7:0] !== in_q[0]) begin
                            errors++; $display("FAIL stress_in got %02h want %02h", cmp_data[7:0], (in_q.size() == 0) ? 8'h00 : in_q[0]);
                        end
                        if (in_q.size() != 0) void'(in_q.pop_front());
                    end
                end
                cmp_ready[0] = 1'b0;
            end
        join
        checks++; if (rd_cnt !== 48) begin errors++; $display("FAIL stress_read_count got %0d want 48", rd_cnt); end
        checks++; if (in_q.size() != 0) begin errors++; $display("FAIL stress_in_left got %0d want 0", in_q.size()); end
        checks++; if (cmp_valid[0] !== 1'b0) begin errors++; $display("FAIL stress_in_empty got %0b want 0", cmp_valid[0]); end
        bus(1'b0, 8'h04, 32'd0, rd, ack);
        checks++; if (rd[4] !== 1'b0 || rd[23:8] !== 16'd0) begin errors++; $display("FAIL stress_status got %08h want ovf=0 levels=0", rd); end
    endtask

    task automatic test_reset_mid_transaction();
        logic [31:0] rd;
        logic ack;
        bus(1'b1, 8'h08, 32'h2, rd, ack);
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ie_in_irq got %0b want 1", irq); end
        @(negedge clk);
        valid = 1'b1;
        wr_en = 1'b1;
        addr  = 8'h10;
        wdata = 32'h55;
        rst   = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b0 || rdata !== 32'd0 || irq !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs got ready=%0b rdata=%08h irq=%0b want 0 0 0", ready, rdata, irq);
        end
        checks++; if (cmp_valid !== 2'b00 || dcmp_ready !== 2'b11) begin
            errors++; $display("FAIL rst_mid_stream got v=%b r=%b want 00 11", cmp_valid, dcmp_ready);
        end
        valid = 1'b0;
        wr_en = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_no_ack got %0b want 0", ready); end
        bus(1'b0, 8'h14, 32'd0, rd, ack);
        checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL rst_ch1_status got %08h want 0000000a", rd); end
        bus(1'b0, 8'h08, 32'd0, rd, ack);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_ctrl got %08h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_stream_order();
        test_overflow();
        test_irq_data_read();
        test_flush();
        test_reserved();
        test_back_to_back_stress();
        test_reset_mid_transaction();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
